timer32_bus_bridge: RTL and testbench
=====================================

Name: timer32_bus_bridge

Overview:
- Bridges the CPU's single-outstanding request/response memory bus to the register port of the 32-bit timer peripheral (registers: 0 count, 1 period, 2 control/status).
- Decodes the timer's address window and checks alignment and byte enables.
- Issues exactly one single-cycle write or read strobe per legal access and returns the captured read data with a response pulse.
- Sits directly upstream of the timer: it is the only source of the timer's din/wren/rden/addr and the only consumer of its dout.

Parameters:
- BASE_ADDR, 32'h1100_0000, byte base of the 16-byte timer window; bits [3:0] are ignored.
- ERR_RDATA, 32'hDEAD_BEEF, value returned on cpu_rdata for errored reads.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  request valid
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data
- cpu_be  in  4  byte enables
- cpu_ready  out  1  bridge can accept a request this cycle
- cpu_rvalid  out  1  one-cycle response pulse (reads and writes)
- cpu_rdata  out  32  read data, valid while cpu_rvalid
- cpu_err  out  1  error flag, valid while cpu_rvalid
- tmr_din  out  32  timer write data
- tmr_wren  out  1  timer write strobe
- tmr_rden  out  1  timer read strobe
- tmr_addr  out  2  timer register index
- tmr_dout  in  32  timer read data; combinational from the timer, valid in the rden cycle

Behaviour:
- Reset is asynchronous, active-high; clock is clk. Reset values: state IDLE, cpu_ready=1, every other output 0.
- Reset asserted mid-transaction: strobes drop immediately, the pending transaction is discarded, no response is issued.
- State machine IDLE -> ACCESS -> RESP:
  - IDLE: cpu_ready=1.
  - RESP: cpu_ready=1.
  - ACCESS: cpu_ready=0.
- Accept occurs when cpu_req && cpu_ready. On accept, register we, offset=cpu_addr[3:2], wdata and the error decision, then go to ACCESS.
- ACCESS lasts exactly 1 cycle:
  - Legal write: tmr_wren=1, tmr_addr=offset, tmr_din=wdata.
  - Legal read: tmr_rden=1, tmr_addr=offset; tmr_dout is sampled into the rdata register at the end of this cycle.
  - Errored access: no strobe.
  - Next state is RESP.
- RESP lasts exactly 1 cycle:
  - cpu_rvalid=1.
  - cpu_err = the registered error decision.
  - cpu_rdata = captured data for a legal read; ERR_RDATA for an errored read; 0 for any write.
  - If cpu_req is present in RESP it is accepted (next state ACCESS); otherwise next state is IDLE.
- Latency: request accepted in cycle N -> strobe in N+1 -> response in N+2. Maximum throughput is one access per 2 cycles.
- Error conditions, evaluated at accept; any one is sufficient:
  - cpu_addr[31:4] != BASE_ADDR[31:4] (window miss);
  - cpu_addr[1:0] != 0 (misaligned);
  - offset == 3 (unimplemented register);
  - write with cpu_be != 4'hF (partial write unsupported).
  - cpu_be is ignored on reads.
- Strobe rules:
  - tmr_wren and tmr_rden are never high together.
  - Each is high for at most one cycle per accepted transaction; never speculative.
  - tmr_rden is critical because reading register 2 clears the timer's flag.
- When no strobe is active, tmr_din=0 and tmr_addr=0.
- cpu_rdata and cpu_err are 0 whenever cpu_rvalid=0.
- cpu_req while cpu_ready=0 is ignored; the requester must hold the request until accepted.

Test Plan:
- Write 32'h0000_0020 to 0x1100_0004 with be=F -> tmr_wren=1, tmr_addr=1, tmr_din=0x20 for exactly one cycle at N+1; cpu_rvalid=1, err=0, rdata=0 at N+2.
- Read 0x1100_0008 while the timer drives tmr_dout=32'h5 -> exactly one tmr_rden pulse with tmr_addr=2; cpu_rdata=0x5 at N+2; no second rden pulse.
- Back-to-back requests: read 0x1100_0000 presented in the RESP cycle of a prior write -> accepted immediately; strobes spaced exactly 2 cycles apart; one response per request, in order.
- Errors: read of 0x1100_000C, read of 0x1100_0002, read of 0x1200_0000, and write to 0x1100_0000 with be=4'h3 -> no tmr strobes; cpu_err=1; read rdata=0xDEADBEEF, write rdata=0.
- Assert reset during ACCESS of a read -> tmr_rden deasserts within the same cycle; no cpu_rvalid; after release cpu_ready=1 and all other outputs 0.
- Hold cpu_req during ACCESS with changing cpu_addr -> ignored until RESP; the value sampled in RESP is the one executed.

Source files
------------

// File: rtl/timer32_bus_bridge.sv
// Bridge between the CPU single-outstanding request/response bus and the
// register port of the 32-bit timer. One strobe per legal access, one response per accept.
module timer32_bus_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_be,
    output logic        cpu_ready,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic [31:0] tmr_din,
    output logic        tmr_wren,
    output logic        tmr_rden,
    output logic [1:0]  tmr_addr,
    input  logic [31:0] tmr_dout
);

    // cpu handshake: a request is taken on any rising edge where cpu_req and
    // cpu_ready are both high; cpu_rvalid is a one-cycle pulse qualifying
    // cpu_rdata/cpu_err, with no backpressure on the response side.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        acc_err;
    logic        we_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_q;

    assign accept = cpu_req && cpu_ready;

    // Any single condition is enough to refuse the access; cpu_be only matters for writes.
    always_comb begin
        acc_err = 1'b0;
        if (cpu_addr[31:4] != BASE_ADDR[31:4]) acc_err = 1'b1;
        if (cpu_addr[1:0] != 2'b00)            acc_err = 1'b1;
        if (cpu_addr[3:2] == 2'd3)             acc_err = 1'b1;
        if (cpu_we && (cpu_be != 4'hF))        acc_err = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? ACCESS : IDLE;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = accept ? ACCESS : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            off_q   <= 2'd0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            if (accept) begin
                we_q    <= cpu_we;
                off_q   <= cpu_addr[3:2];
                wdata_q <= cpu_wdata;
                err_q   <= acc_err;
            end
            // The response word is settled here so RESP only has to gate it out.
            if (state == ACCESS) begin
                if (we_q)       rdata_q <= 32'd0;
                else if (err_q) rdata_q <= ERR_RDATA;
                else            rdata_q <= tmr_dout;
            end
        end
    end

    always_comb begin
        cpu_ready  = 1'b0;
        cpu_rvalid = 1'b0;
        cpu_rdata  = 32'd0;
        cpu_err    = 1'b0;
        tmr_din    = 32'd0;
        tmr_wren   = 1'b0;
        tmr_rden   = 1'b0;
        tmr_addr   = 2'd0;
        case (state)
            IDLE: cpu_ready = 1'b1;
            ACCESS: begin
                if (!err_q) begin
                    tmr_addr = off_q;
                    if (we_q) begin
                        tmr_wren = 1'b1;
                        tmr_din  = wdata_q;
                    end else begin
                        tmr_rden = 1'b1;
                    end
                end
            end
            RESP: begin
                cpu_ready  = 1'b1;
                cpu_rvalid = 1'b1;
                cpu_rdata  = rdata_q;
                cpu_err    = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_timer32_bus_bridge.sv
// Directed bench for timer32_bus_bridge: expected strobes and responses are
// queued by the driver and checked by a negedge monitor.
module tb_timer32_bus_bridge;

    localparam int STW = 67; // {wr, addr[1:0], din[31:0], cycle[31:0]}
    localparam int RSW = 65; // {rdata[31:0], err, cycle[31:0]}

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_be;
    logic        cpu_ready;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic [31:0] tmr_din;
    logic        tmr_wren;
    logic        tmr_rden;
    logic [1:0]  tmr_addr;
    logic [31:0] tmr_dout;

    logic [STW-1:0] exp_strb_q[$];
    logic [RSW-1:0] exp_q[$];
    int checks;
    int failures;
    int cyc;
    logic mon_en;

    timer32_bus_bridge dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_ready(cpu_ready),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .tmr_din(tmr_din), .tmr_wren(tmr_wren), .tmr_rden(tmr_rden),
        .tmr_addr(tmr_addr), .tmr_dout(tmr_dout)
    );

    // clock / reset / timer model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        case (tmr_addr)
            2'd0:    tmr_dout = 32'h1234_5678;
            2'd1:    tmr_dout = 32'h0000_0020;
            2'd2:    tmr_dout = 32'h0000_0005;
            default: tmr_dout = 32'h0000_0000;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            logic [STW-1:0] es;
            logic [RSW-1:0] er;
            check("strobe_exclusive", {63'd0, tmr_wren & tmr_rden}, 64'd0);
            if (tmr_wren || tmr_rden) begin
                if (exp_strb_q.size() == 0) begin
                    check("unexpected_strobe", {62'd0, tmr_wren, tmr_rden}, 64'd0);
                end else begin
                    es = exp_strb_q.pop_front();
                    check("strobe_kind", {63'd0, tmr_wren}, {63'd0, es[66]});
                    check("strobe_addr", {62'd0, tmr_addr}, {62'd0, es[65:64]});
                    check("strobe_din", {32'd0, tmr_din}, {32'd0, es[63:32]});
                    check("strobe_cycle", {32'd0, cyc}, {32'd0, es[31:0]});
                end
            end else begin
                check("idle_tmr_bus", {30'd0, tmr_addr, tmr_din}, 64'd0);
            end
            if (cpu_rvalid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rvalid", 64'd1, 64'd0);
                end else begin
                    er = exp_q.pop_front();
                    check("rsp_rdata", {32'd0, cpu_rdata}, {32'd0, er[64:33]});
                    check("rsp_err", {63'd0, cpu_err}, {63'd0, er[32]});
                    check("rsp_cycle", {32'd0, cyc}, {32'd0, er[31:0]});
                end
            end else begin
                check("idle_rsp", {31'd0, cpu_err, cpu_rdata}, 64'd0);
            end
        end
    end

    task automatic push_exp(input int k, input logic we, input logic [1:0] off,
                            input logic [31:0] wdata, input logic err, input logic [31:0] rdata);
        if (!err) exp_strb_q.push_back({we, off, (we ? wdata : 32'd0), k + 1});
        exp_q.push_back({rdata, err, k + 2});
    endtask

    // driver: called at a negedge, returns at the negedge after the accept edge
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic err, input logic [31:0] rdata);
        int wait_cnt;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_be    = be;
        wait_cnt  = 0;
        while (!cpu_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (!cpu_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else begin
            push_exp(cyc, we, addr[3:2], wdata, err, rdata);
            @(posedge clk);
        end
        @(negedge clk);
        cpu_req = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        mon_en    = 1'b0;
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 32'd0;
        cpu_wdata = 32'd0;
        cpu_be    = 4'h0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {cpu_ready, cpu_rvalid, cpu_err, tmr_wren, tmr_rden, tmr_addr, cpu_rdata, tmr_din[24:0]},
              {1'b1, 63'd0});
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // legal write then legal read of the status register
        issue(1'b1, 32'h1100_0004, 32'h0000_0020, 4'hF, 1'b0, 32'h0);
        idle_cycles(3);
        issue(1'b0, 32'h1100_0008, 32'h0, 4'h0, 1'b0, 32'h0000_0005);
        idle_cycles(3);

        // back-to-back: read presented in ACCESS, held, taken in RESP
        issue(1'b1, 32'h1100_0000, 32'hA5A5_0001, 4'hF, 1'b0, 32'h0);
        issue(1'b0, 32'h1100_0000, 32'h0, 4'h0, 1'b0, 32'h1234_5678);
        issue(1'b0, 32'h1100_0004, 32'h0, 4'h0, 1'b0, 32'h0000_0020);
        idle_cycles(3);

        // error cases: no strobes
        issue(1'b0, 32'h1100_000C, 32'h0, 4'hF, 1'b1, 32'hDEAD_BEEF);
        issue(1'b0, 32'h1100_0002, 32'h0, 4'hF, 1'b1, 32'hDEAD_BEEF);
        issue(1'b0, 32'h1200_0000, 32'h0, 4'hF, 1'b1, 32'hDEAD_BEEF);
        issue(1'b1, 32'h1100_0000, 32'h1111_2222, 4'h3, 1'b1, 32'h0);
        issue(1'b1, 32'h1100_0008, 32'h3333_4444, 4'hF, 1'b0, 32'h0);
        idle_cycles(3);

        // request changes address during ACCESS; the RESP-cycle value is executed
        issue(1'b1, 32'h1100_0004, 32'h0000_0040, 4'hF, 1'b0, 32'h0);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h1200_0000;
        @(negedge clk);
        cpu_addr = 32'h1100_0000;
        check("ready_in_resp", {63'd0, cpu_ready}, 64'd1);
        push_exp(cyc, 1'b0, 2'd0, 32'h0, 1'b0, 32'h1234_5678);
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        idle_cycles(3);

        // reset during ACCESS of a legal read
        mon_en   = 1'b0;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h1100_0008;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        check("rden_before_reset", {63'd0, tmr_rden}, 64'd1);
        #1 reset = 1'b1;
        #1;
        check("rden_dropped_by_reset", {62'd0, tmr_rden, cpu_rvalid}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_reset_outputs",
              {cpu_ready, cpu_rvalid, cpu_err, tmr_wren, tmr_rden, tmr_addr, cpu_rdata, tmr_din[24:0]},
              {1'b1, 63'd0});
        @(negedge clk);
        mon_en = 1'b1;
        idle_cycles(4);

        check("strobe_queue_drained", 64'(exp_strb_q.size()), 64'd0);
        check("rsp_queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
